rotation_cordic: RTL

- Iterative rotation-mode CORDIC that converts polar to Cartesian: magnitude and angle in, x (output_1) and y (output_2) out.
- It is the inverse companion of vector_cordic and uses the same Q(INT_WIDTH).(FRACT_WIDTH) signed format and the same enable/valid handshake style.
- Angle is in radians. The CORDIC gain is pre-compensated, so outputs are true x = mag·cos(angle) and y = mag·sin(angle).
- Sits downstream of vector_cordic in the polar-processing chain (rotate/modify, then back to Cartesian).

---
 rtl/rotation_cordic.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rotation_cordic.sv
// Iterative rotation-mode CORDIC: polar (magnitude, angle in radians) to Cartesian x/y.
// Gain is pre-compensated on the magnitude; angles outside +/-pi/2 are folded by pi first.
module rotation_cordic #(
  parameter int NUMBER_OF_ITERATIONS = 7,
  parameter int INT_WIDTH            = 6,
  parameter int FRACT_WIDTH          = 12
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      rotation_cordic_enable,
  input  logic signed [INT_WIDTH+FRACT_WIDTH-1:0]   input_mag,
  input  logic signed [INT_WIDTH+FRACT_WIDTH-1:0]   input_angle,
  output logic                                      rotation_cordic_valid,
  output logic signed [INT_WIDTH+FRACT_WIDTH-1:0]   output_1,
  output logic signed [INT_WIDTH+FRACT_WIDTH-1:0]   output_2
);

  localparam int DW = INT_WIDTH + FRACT_WIDTH;
  localparam int XW = DW + 2;
  localparam int ZW = DW + 1;
  localparam int CW = $clog2(NUMBER_OF_ITERATIONS + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(NUMBER_OF_ITERATIONS - 1);

  function automatic logic signed [31:0] to_fract(input logic signed [31:0] c16);
    int sh;
    sh = 16 - FRACT_WIDTH;
    if (sh == 0) begin
      to_fract = c16;
    end else begin
      to_fract = (c16 + (32'sd1 <<< (sh - 1))) >>> sh;
    end
  endfunction

  function automatic logic signed [31:0] atan16(input logic [CW-1:0] idx);
    case (int'(idx))
      0:       atan16 = 32'sd51472;
      1:       atan16 = 32'sd30386;
      2:       atan16 = 32'sd16055;
      3:       atan16 = 32'sd8150;
      4:       atan16 = 32'sd4091;
      5:       atan16 = 32'sd2047;
      6:       atan16 = 32'sd1024;
      7:       atan16 = 32'sd512;
      8:       atan16 = 32'sd256;
      9:       atan16 = 32'sd128;
      10:      atan16 = 32'sd64;
      11:      atan16 = 32'sd32;
      default: atan16 = 32'sd0;
    endcase
  endfunction

  localparam logic signed [DW-1:0] K_Q    = DW'(to_fract(32'sd39797));
  localparam logic signed [ZW-1:0] PI_Z   = ZW'(to_fract(32'sd205887));
  localparam logic signed [ZW-1:0] HPI_Z  = ZW'(to_fract(32'sd102944));
  localparam logic signed [XW-1:0] SAT_HI = XW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] SAT_LO = ~SAT_HI;

  function automatic logic signed [DW-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_HI) begin
      sat = SAT_HI[DW-1:0];
    end else if (v < SAT_LO) begin
      sat = SAT_LO[DW-1:0];
    end else begin
      sat = v[DW-1:0];
    end
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                 state_r;
  logic signed [XW-1:0]   x_r, y_r;
  logic signed [ZW-1:0]   z_r;
  logic [CW-1:0]          iter_r;

  logic signed [2*DW-1:0] prod_s;
  logic signed [XW-1:0]   xk_s, x0_s;
  logic signed [ZW-1:0]   ang_s, z0_s;
  logic signed [XW-1:0]   x_sh_s, y_sh_s, x_nxt_s, y_nxt_s;
  logic signed [ZW-1:0]   atan_s, z_nxt_s;

  // Operand conditioning: gain pre-scale and quadrant fold applied at the capture edge
  always_comb begin
    prod_s = (2*DW)'(input_mag) * (2*DW)'(K_Q);
    xk_s   = XW'(prod_s >>> FRACT_WIDTH);
    ang_s  = ZW'(input_angle);
    if (ang_s > HPI_Z) begin
      z0_s = ang_s - PI_Z;
      x0_s = -xk_s;
    end else if (ang_s < -HPI_Z) begin
      z0_s = ang_s + PI_Z;
      x0_s = -xk_s;
    end else begin
      z0_s = ang_s;
      x0_s = xk_s;
    end
  end

  // One micro-rotation, direction chosen by the sign of the residual angle
  always_comb begin
    atan_s = ZW'(to_fract(atan16(iter_r)));
    x_sh_s = x_r >>> iter_r;
    y_sh_s = y_r >>> iter_r;
    if (!z_r[ZW-1]) begin
      x_nxt_s = x_r - y_sh_s;
      y_nxt_s = y_r + x_sh_s;
      z_nxt_s = z_r - atan_s;
    end else begin
      x_nxt_s = x_r + y_sh_s;
      y_nxt_s = y_r - x_sh_s;
      z_nxt_s = z_r + atan_s;
    end
  end

  // Control FSM with datapath registers and registered, saturated outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r               <= S_IDLE;
      x_r                   <= {XW{1'b0}};
      y_r                   <= {XW{1'b0}};
      z_r                   <= {ZW{1'b0}};
      iter_r                <= {CW{1'b0}};
      rotation_cordic_valid <= 1'b0;
      output_1              <= {DW{1'b0}};
      output_2              <= {DW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          rotation_cordic_valid <= 1'b0;
          if (rotation_cordic_enable) begin
            x_r     <= x0_s;
            y_r     <= {XW{1'b0}};
            z_r     <= z0_s;
            iter_r  <= {CW{1'b0}};
            state_r <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          x_r    <= x_nxt_s;
          y_r    <= y_nxt_s;
          z_r    <= z_nxt_s;
          iter_r <= iter_r + CW'(1);
          if (iter_r == LAST_ITER) begin
            state_r <= S_DONE;
          end
        end
        S_DONE: begin
          output_1              <= sat(x_r);
          output_2              <= sat(y_r);
          rotation_cordic_valid <= 1'b1;
          state_r               <= S_IDLE;
        end
        default: begin
          rotation_cordic_valid <= 1'b0;
          state_r               <= S_IDLE;
        end
      endcase
    end
  end

endmodule
